pc_next_unit: RTL



---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_target_mux.sv | 28 ++
 rtl/pc_next_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage PC unit: target-select encodings and
// the default address width and exception vector.
package pc_pkg;

  localparam int          DEF_ADDR_W  = 11;
  localparam logic [10:0] DEF_EXC_VEC = 11'h180;

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_J      = 2'b01;
  localparam logic [1:0] SEL_JR     = 2'b10;
  localparam logic [1:0] SEL_EXC    = 2'b11;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational 4:1 jump-target select; encoding 11 picks the exception
// vector rather than aliasing onto the branch target.
module pc_target_mux
  import pc_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] j_addr,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic [1:0]        sel,
  output logic [ADDR_W-1:0] target
);

  // Target selection by jump class
  always_comb begin
    target = branch_addr;
    case (sel)
      SEL_BRANCH: target = branch_addr;
      SEL_J:      target = j_addr;
      SEL_JR:     target = jr_addr;
      SEL_EXC:    target = EXC_VEC;
      default:    target = branch_addr;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch PC with sequential increment, redirect, stall hold and a
// one-deep pending-redirect buffer; also drives flush and a redirect counter.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 1,
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(DEF_EXC_VEC),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Branch_dest_addr,
  input  logic [ADDR_W-1:0] J_JAL_dest_addr,
  input  logic [ADDR_W-1:0] JR_JALR_dest_addr,
  input  logic [1:0]        sel_dire_salto,
  input  logic              redirect_valid,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              flush,
  output logic              pending,
  output logic [CNT_W-1:0]  redirect_count
);

  localparam logic [ADDR_W-1:0] INC_W   = ADDR_W'(INC);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pending_addr_r;
  logic              pending_r;
  logic              flush_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_inc_s;

  pc_target_mux #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_target_mux (
    .branch_addr (Branch_dest_addr),
    .j_addr      (J_JAL_dest_addr),
    .jr_addr     (JR_JALR_dest_addr),
    .sel         (sel_dire_salto),
    .target      (target_s)
  );

  // Saturating next value of the redirect counter
  always_comb begin
    count_inc_s = count_r;
    if (count_r == CNT_MAX) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + CNT_ONE;
    end
  end

  // PC, pending buffer, flush and counter state; a live redirect beats the buffered one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r           <= RESET_PC;
      pending_r      <= 1'b0;
      pending_addr_r <= '0;
      flush_r        <= 1'b0;
      count_r        <= '0;
    end else if (!stall) begin
      if (redirect_valid) begin
        pc_r      <= target_s;
        pending_r <= 1'b0;
        flush_r   <= 1'b1;
        count_r   <= count_inc_s;
      end else if (pending_r) begin
        pc_r      <= pending_addr_r;
        pending_r <= 1'b0;
        flush_r   <= 1'b1;
        count_r   <= count_inc_s;
      end else begin
        pc_r    <= pc_r + INC_W;
        flush_r <= 1'b0;
      end
    end else begin
      flush_r <= 1'b0;
      if (redirect_valid) begin
        pending_addr_r <= target_s;
        pending_r      <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign pc             = pc_r;
  assign pc_plus_inc    = pc_r + INC_W;
  assign flush          = flush_r;
  assign pending        = pending_r;
  assign redirect_count = count_r;

endmodule
